// File: rtl/dtree_host_ctrl.sv
// dtree_host_ctrl: host sequencer for a decision-tree core.
// Walks tree symbols, fetches features, swaps ROM pages, reports a label.
module dtree_host_ctrl #(
    parameter int unsigned DATA_LEN    = 4,
    parameter int unsigned PC_LEN      = 7,
    parameter int unsigned INSTR_LEN   = 8,
    parameter int unsigned NPAGES      = 3,
    parameter int unsigned PAGE_W      = 2,
    parameter logic [INSTR_LEN-1:0] BR0_INSTR = INSTR_LEN'(8'b1000_0000),
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [DATA_LEN-1:0]  OPORT,
    input  logic [PC_LEN-1:0]    PC,
    input  logic [INSTR_LEN-1:0] ROM_INSTR,
    input  logic                 FEAT_ACK,
    input  logic [DATA_LEN-1:0]  FEAT_DATA,
    output logic [INSTR_LEN-1:0] INSTR,
    output logic [DATA_LEN-1:0]  IPORT,
    output logic                 CORE_RSTN,
    output logic                 CORE_HOLD,
    output logic [PAGE_W-1:0]    PAGE_SEL,
    output logic                 FEAT_REQ,
    output logic [DATA_LEN-1:0]  FEAT_IDX,
    output logic [1:0]           LABEL,
    output logic                 LABEL_VALID,
    output logic                 ERR
);

    typedef enum logic [3:0] {
        S_START,
        S_OTH0,
        S_OTH1,
        S_OTH2,
        S_OPR0,
        S_OPR1,
        S_OPR2,
        S_FWAIT,
        S_FREQ,
        S_FFETCH,
        S_RESTART,
        S_PAGE,
        S_CHILD,
        S_DONE
    } state_t;

    localparam logic [PAGE_W+1:0] NP_L    = (PAGE_W+2)'(NPAGES);
    localparam logic [15:0]       WD_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            nxt;
    logic [1:0]        sym;
    logic [1:0]        lbl;
    logic              bad_child;
    logic [PAGE_W+1:0] child;
    logic [15:0]       wd;

    assign sym = OPORT[1:0];

    // Heap-ordered child page: 2*page + 1 + sym[0]
    assign child = {1'b0, PAGE_SEL, 1'b1}
                 + {{(PAGE_W+1){1'b0}}, sym[0]};

    assign INSTR = (state == S_PAGE && PC != '0) ? BR0_INSTR
                                                 : ROM_INSTR;

    always_comb begin
        nxt       = state;
        lbl       = LABEL;
        bad_child = 1'b0;
        unique case (state)
            S_START: begin
                if (sym == 2'd1)
                    nxt = S_OPR0;
                else if (sym == 2'd2)
                    nxt = S_OTH0;
            end
            S_OTH0: begin
                if (sym == 2'd0)
                    nxt = S_OTH2;
                else if (sym == 2'd1)
                    nxt = S_OTH1;
            end
            S_OTH1: begin
                if (sym == 2'd2)
                    nxt = S_FWAIT;
            end
            S_OTH2: begin
                if (sym == 2'd1) begin
                    nxt = S_DONE;
                    lbl = 2'd0;
                end else if (sym == 2'd2) begin
                    nxt = S_DONE;
                    lbl = 2'd1;
                end
            end
            S_OPR0: begin
                if (sym == 2'd0)
                    nxt = S_OPR2;
                else if (sym == 2'd2)
                    nxt = S_OPR1;
            end
            S_OPR1: begin
                if (sym == 2'd0 || sym == 2'd1) begin
                    if (child >= NP_L) begin
                        nxt       = S_DONE;
                        bad_child = 1'b1;
                    end else begin
                        nxt = S_RESTART;
                    end
                end
            end
            S_OPR2: begin
                if (sym == 2'd1) begin
                    nxt = S_DONE;
                    lbl = 2'd3;
                end else if (sym == 2'd2) begin
                    nxt = S_DONE;
                    lbl = 2'd2;
                end
            end
            S_FWAIT:   nxt = S_FREQ;
            S_FREQ: begin
                if (FEAT_ACK)
                    nxt = S_FFETCH;
            end
            S_FFETCH: begin
                if (sym == 2'd3)
                    nxt = S_START;
            end
            S_RESTART: nxt = S_PAGE;
            S_PAGE: begin
                if (PC == '0)
                    nxt = S_CHILD;
            end
            S_CHILD: begin
                if (sym == 2'd3)
                    nxt = S_START;
            end
            S_DONE:    nxt = S_DONE;
            default:   nxt = S_START;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= S_START;
            PAGE_SEL    <= '0;
            IPORT       <= '0;
            FEAT_IDX    <= '0;
            LABEL       <= '0;
            FEAT_REQ    <= 1'b0;
            LABEL_VALID <= 1'b0;
            ERR         <= 1'b0;
            CORE_HOLD   <= 1'b0;
            CORE_RSTN   <= 1'b0;
            wd          <= '0;
        end else begin
            CORE_RSTN <= 1'b1;
            if (nxt != state) begin
                state <= nxt;
                wd    <= '0;
                if (nxt == S_FREQ) begin
                    FEAT_IDX  <= OPORT;
                    FEAT_REQ  <= 1'b1;
                    CORE_HOLD <= 1'b1;
                end
                if (state == S_FREQ) begin
                    IPORT     <= FEAT_DATA;
                    FEAT_REQ  <= 1'b0;
                    CORE_HOLD <= 1'b0;
                end
                if (nxt == S_RESTART) begin
                    PAGE_SEL  <= child[PAGE_W-1:0];
                    CORE_RSTN <= 1'b0;
                end
                if (nxt == S_DONE) begin
                    LABEL_VALID <= 1'b1;
                    CORE_HOLD   <= 1'b1;
                    if (bad_child)
                        ERR <= 1'b1;
                    else
                        LABEL <= lbl;
                end
            end else if (state != S_FREQ && state != S_DONE) begin
                // A feature wait may legitimately stall forever
                if (wd == WD_LAST) begin
                    state       <= S_DONE;
                    ERR         <= 1'b1;
                    LABEL_VALID <= 1'b1;
                    CORE_HOLD   <= 1'b1;
                end else begin
                    wd <= wd + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dtree_host_ctrl.sv
// Bench for dtree_host_ctrl: table-driven reference model,
// per-cycle compare, directed scenarios and random traffic.
module tb_dtree_host_ctrl;

    localparam int TO = 16;
    localparam int NP = 3;

    logic       CLK  = 1'b0;
    logic       RSTN = 1'b0;
    logic [3:0] OPORT = '0;
    logic [6:0] PC = '0;
    logic [7:0] ROM_INSTR = '0;
    logic       FEAT_ACK = 1'b0;
    logic [3:0] FEAT_DATA = '0;
    logic [7:0] INSTR;
    logic [3:0] IPORT;
    logic       CORE_RSTN;
    logic       CORE_HOLD;
    logic [1:0] PAGE_SEL;
    logic       FEAT_REQ;
    logic [3:0] FEAT_IDX;
    logic [1:0] LABEL;
    logic       LABEL_VALID;
    logic       ERR;

    int errors = 0;
    int checks = 0;

    dtree_host_ctrl #(
        .NPAGES(NP),
        .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .OPORT(OPORT),
        .PC(PC),
        .ROM_INSTR(ROM_INSTR),
        .FEAT_ACK(FEAT_ACK),
        .FEAT_DATA(FEAT_DATA),
        .INSTR(INSTR),
        .IPORT(IPORT),
        .CORE_RSTN(CORE_RSTN),
        .CORE_HOLD(CORE_HOLD),
        .PAGE_SEL(PAGE_SEL),
        .FEAT_REQ(FEAT_REQ),
        .FEAT_IDX(FEAT_IDX),
        .LABEL(LABEL),
        .LABEL_VALID(LABEL_VALID),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: tree walk as lookup tables keyed by "<node><sym>"
    string tbl[string];
    int    lab[string];
    string m_st = "START";
    int    m_page = 0;
    int    m_wd = 0;
    int    m_iport = 0;
    int    m_idx = 0;
    int    m_label = 0;
    bit    m_err = 0;
    bit    m_first = 1;

    function automatic void init_tables();
        tbl["START1"]  = "OPR0";
        tbl["START2"]  = "OTH0";
        tbl["OTH00"]   = "OTH2";
        tbl["OTH01"]   = "OTH1";
        tbl["OTH12"]   = "FWAIT";
        tbl["OTH21"]   = "DONE";
        tbl["OTH22"]   = "DONE";
        tbl["OPR00"]   = "OPR2";
        tbl["OPR02"]   = "OPR1";
        tbl["OPR10"]   = "RESTART";
        tbl["OPR11"]   = "RESTART";
        tbl["OPR21"]   = "DONE";
        tbl["OPR22"]   = "DONE";
        tbl["FFETCH3"] = "START";
        tbl["CHILD3"]  = "START";
        lab["OTH21"] = 0;
        lab["OTH22"] = 1;
        lab["OPR21"] = 3;
        lab["OPR22"] = 2;
    endfunction

    function automatic void model_reset();
        m_st    = "START";
        m_page  = 0;
        m_wd    = 0;
        m_iport = 0;
        m_idx   = 0;
        m_label = 0;
        m_err   = 0;
        m_first = 1;
    endfunction

    function automatic void model_step();
        int    sym;
        int    c;
        string key;
        string nx;
        sym = int'(OPORT[1:0]);
        key = $sformatf("%s%0d", m_st, sym);
        nx  = m_st;
        m_first = 0;
        if (m_st == "FWAIT")
            nx = "FREQ";
        else if (m_st == "FREQ") begin
            if (FEAT_ACK)
                nx = "FFETCH";
        end else if (m_st == "RESTART")
            nx = "PAGE";
        else if (m_st == "PAGE") begin
            if (PC == 0)
                nx = "CHILD";
        end else if (tbl.exists(key))
            nx = tbl[key];
        if (nx == "RESTART") begin
            c = 2 * m_page + 1 + (sym % 2);
            if (c >= NP) begin
                nx    = "DONE";
                m_err = 1;
            end else begin
                m_page = c;
            end
        end
        if (nx == "FREQ" && m_st != "FREQ")
            m_idx = int'(OPORT);
        if (m_st == "FREQ" && nx == "FFETCH")
            m_iport = int'(FEAT_DATA);
        if (nx == "DONE" && m_st != "DONE" && lab.exists(key))
            m_label = lab[key];
        if (nx != m_st)
            m_wd = 0;
        else if (m_st != "FREQ" && m_st != "DONE") begin
            m_wd++;
            if (m_wd == TO) begin
                nx    = "DONE";
                m_err = 1;
            end
        end
        m_st = nx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t st=%s)",
                     name, act, exp, $time, m_st);
        end
    endtask

    task automatic compare();
        logic [7:0] e_instr;
        e_instr = (m_st == "PAGE" && PC != 0) ? 8'h80 : ROM_INSTR;
        chk("instr", INSTR, e_instr);
        chk("iport", IPORT, m_iport);
        chk("core_rstn", CORE_RSTN, !(m_first || m_st == "RESTART"));
        chk("core_hold", CORE_HOLD, m_st == "FREQ" || m_st == "DONE");
        chk("page_sel", PAGE_SEL, m_page);
        chk("feat_req", FEAT_REQ, m_st == "FREQ");
        chk("feat_idx", FEAT_IDX, m_idx);
        chk("label", LABEL, m_label);
        chk("label_valid", LABEL_VALID, m_st == "DONE");
        chk("err", ERR, m_err);
    endtask

    always @(negedge RSTN) model_reset();

    always @(posedge CLK) begin
        if (RSTN)
            model_step();
        else
            model_reset();
        #1;
        compare();
    end

    task automatic cyc(input logic [3:0] op, input logic [6:0] pc,
                       input logic ack, input logic [3:0] fd,
                       input logic [7:0] rom);
        @(negedge CLK);
        OPORT     = op;
        PC        = pc;
        FEAT_ACK  = ack;
        FEAT_DATA = fd;
        ROM_INSTR = rom;
        @(posedge CLK);
        #2;
    endtask

    task automatic sym(input logic [3:0] op);
        cyc(op, 7'd9, 1'b0, 4'h0, 8'h11);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        OPORT    = '0;
        FEAT_ACK = 1'b0;
        RSTN     = 1'b0;
        #1;
        chk("rst_feat_req", FEAT_REQ, 0);
        chk("rst_hold", CORE_HOLD, 0);
        chk("rst_core_rstn", CORE_RSTN, 0);
        chk("rst_label_valid", LABEL_VALID, 0);
        chk("rst_err", ERR, 0);
        chk("rst_page", PAGE_SEL, 0);
        chk("rst_label", LABEL, 0);
        chk("rst_iport", IPORT, 0);
        chk("rst_feat_idx", FEAT_IDX, 0);
        @(posedge CLK);
        #2;
        RSTN = 1'b1;
    endtask

    int nreq;
    int done_cnt;

    initial begin
        init_tables();
        model_reset();

        // Reset release and the direct path 1,0,1 -> label 3
        do_reset();
        chk("core_rstn_held", CORE_RSTN, 0);
        sym(4'd1);
        chk("core_rstn_up", CORE_RSTN, 1);
        sym(4'd0);
        chk("lv_before", LABEL_VALID, 0);
        sym(4'd1);
        chk("lbl_101", LABEL, 3);
        chk("lv_101", LABEL_VALID, 1);
        chk("hold_done", CORE_HOLD, 1);
        sym(4'd2);
        chk("lbl_sticky", LABEL, 3);

        // Direct path 2,0,2 -> label 1
        do_reset();
        sym(4'd2);
        sym(4'd0);
        sym(4'd2);
        chk("lbl_202", LABEL, 1);
        chk("lv_202", LABEL_VALID, 1);

        // Feature fetch with ack in the fifth FREQ cycle
        do_reset();
        sym(4'd2);
        sym(4'd1);
        sym(4'd2);
        sym(4'h6);
        chk("fidx", FEAT_IDX, 6);
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            if (FEAT_REQ && CORE_HOLD)
                nreq++;
            cyc(4'h6, 7'd9, i == 4, 4'hA, 8'h11);
        end
        chk("req_cycles", nreq, 5);
        chk("iport_a", IPORT, 4'hA);
        chk("req_drop", FEAT_REQ, 0);
        chk("hold_drop", CORE_HOLD, 0);
        cyc(4'h3, 7'd9, 1'b1, 4'h5, 8'h11);
        sym(4'd1);
        sym(4'd0);
        sym(4'd2);
        chk("lbl_after_fetch", LABEL, 2);
        chk("iport_kept", IPORT, 4'hA);

        // Ack on the entry cycle, then reset in the middle of FREQ
        do_reset();
        sym(4'd2);
        sym(4'd1);
        sym(4'd2);
        sym(4'h5);
        cyc(4'h5, 7'd9, 1'b1, 4'h3, 8'h11);
        chk("fast_req", FEAT_REQ, 0);
        chk("fast_iport", IPORT, 4'h3);
        sym(4'd3);
        sym(4'd2);
        sym(4'd1);
        sym(4'd2);
        sym(4'h9);
        chk("freq_again", FEAT_REQ, 1);
        do_reset();

        // Page change to page 2, then an out-of-range child
        sym(4'd1);
        sym(4'd2);
        cyc(4'd1, 7'd5, 1'b0, 4'h0, 8'h33);
        chk("restart_rstn", CORE_RSTN, 0);
        chk("restart_page", PAGE_SEL, 2);
        cyc(4'd0, 7'd5, 1'b0, 4'h0, 8'h33);
        chk("page_rstn", CORE_RSTN, 1);
        chk("br0_pc5", INSTR, 8'h80);
        cyc(4'd0, 7'd3, 1'b0, 4'h0, 8'h33);
        chk("br0_pc3", INSTR, 8'h80);
        cyc(4'd0, 7'd1, 1'b0, 4'h0, 8'h33);
        chk("br0_pc1", INSTR, 8'h80);
        cyc(4'd0, 7'd0, 1'b0, 4'h0, 8'h33);
        cyc(4'd0, 7'd4, 1'b0, 4'h0, 8'h5C);
        chk("child_instr", INSTR, 8'h5C);
        sym(4'd3);
        sym(4'd1);
        sym(4'd2);
        sym(4'd0);
        chk("bad_child_err", ERR, 1);
        chk("bad_child_lv", LABEL_VALID, 1);
        chk("bad_child_page", PAGE_SEL, 2);

        // Watchdog: SYM 0 held in START
        do_reset();
        for (int i = 0; i < TO - 1; i++)
            sym(4'd0);
        chk("wd_early", ERR, 0);
        sym(4'd0);
        chk("wd_err", ERR, 1);
        chk("wd_lv", LABEL_VALID, 1);
        do_reset();

        // Random traffic against the model
        done_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (done_cnt > 2 || $urandom_range(0, 149) == 0) begin
                do_reset();
                done_cnt = 0;
            end else begin
                cyc(4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom),
                    $urandom_range(0, 3) == 0,
                    4'($urandom), 8'($urandom));
                if (m_st == "DONE")
                    done_cnt++;
            end
        end

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dtree_host_ctrl.md
DTREE_HOST_CTRL -- requirements
Module: dtree_host_ctrl

Interface
REQ-001 SHALL have parameter DATA_LEN, default 4, core I/O port width.
REQ-002 SHALL have parameter PC_LEN, default 7, core program-counter width.
REQ-003 SHALL have parameter INSTR_LEN, default 8, instruction width.
REQ-004 SHALL have parameter NPAGES, default 3, number of tree ROM pages; legal range 1..2^PAGE_W.
REQ-005 SHALL have parameter PAGE_W, default 2, page-select width.
REQ-006 SHALL have parameter BR0_INSTR, default 8'b1_000_0000, the "BRANCH 0" encoding.
REQ-007 SHALL have parameter TIMEOUT_CYC, default 65535, watchdog limit with a 16-bit counter.
REQ-008 Ports, clock and reset first:
- CLK  in  1  single clock; all state changes on its rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- OPORT  in  DATA_LEN  core output port; SYM = OPORT[1:0].
- PC  in  PC_LEN  core PC.
- ROM_INSTR  in  INSTR_LEN  word read from page PAGE_SEL at PC.
- FEAT_ACK  in  1  feature value valid.
- FEAT_DATA  in  DATA_LEN  feature value.
- INSTR  out  INSTR_LEN  instruction to core.
- IPORT  out  DATA_LEN  core input port.
- CORE_RSTN  out  1  core reset, active-low.
- CORE_HOLD  out  1  core clock-enable gate; 1 freezes the core.
- PAGE_SEL  out  PAGE_W  active ROM page.
- FEAT_REQ  out  1  feature request.
- FEAT_IDX  out  DATA_LEN  requested feature index.
- LABEL  out  2  class label.
- LABEL_VALID  out  1  classification done.
- ERR  out  1  protocol error.

Function
REQ-009 SHALL implement FSM states START, OTH0, OTH1, OTH2, OPR0, OPR1, OPR2, FWAIT, FREQ, FFETCH, RESTART, PAGE, CHILD, DONE, each evaluated on every rising edge from the current SYM.
REQ-010 Transitions; unlisted SYM values hold state:
- START: 1->OPR0; 2->OTH0.
- OTH0: 0->OTH2; 1->OTH1.
- OTH1: 2->FWAIT.
- OTH2: 1->DONE with label 0; 2->DONE with label 1.
- OPR0: 0->OPR2; 2->OPR1.
- OPR1: 0 or 1->RESTART.
- OPR2: 1->DONE with label 3; 2->DONE with label 2.
- FWAIT->FREQ unconditionally.
- FFETCH: 3->START.
- CHILD: 3->START.
REQ-011 On the OPR1 exit, child page SHALL = 2*PAGE_SEL+1+SYM[0] (heap order: left child for SYM=0, right child for SYM=1), computed in PAGE_W+2 bits.
REQ-012 If that child index is >= NPAGES, the FSM SHALL go to DONE with ERR=1 and PAGE_SEL unchanged.
REQ-013 FREQ, entry cycle: SHALL register FEAT_IDX=OPORT and assert FEAT_REQ=1 and CORE_HOLD=1.
REQ-014 FREQ, any cycle with FEAT_ACK=1: SHALL register IPORT=FEAT_DATA, drop FEAT_REQ and CORE_HOLD, and go to FFETCH; FEAT_ACK=1 on the entry cycle is accepted, giving 1-cycle latency.
REQ-015 FEAT_ACK outside FREQ SHALL be ignored.
REQ-016 RESTART: SHALL drive CORE_RSTN=0 for exactly one cycle and update PAGE_SEL to the child, then go to PAGE.
REQ-017 PAGE: INSTR SHALL be BR0_INSTR while PC!=0; on the first edge that samples PC==0 the FSM SHALL go to CHILD.
REQ-018 In all other states INSTR SHALL equal ROM_INSTR, combinationally.
REQ-019 DONE SHALL be sticky until RSTN: LABEL_VALID=1, LABEL held, CORE_HOLD=1.
REQ-020 Watchdog: the counter SHALL clear on every state change and increment otherwise, excluding FREQ and DONE.
REQ-021 If the watchdog reaches TIMEOUT_CYC, the FSM SHALL go to DONE with ERR=1 and LABEL_VALID=1.
REQ-022 SYM=3 in states other than FFETCH and CHILD SHALL be ignored and SHALL NOT set ERR.

Reset
REQ-023 While RSTN=0 (asynchronous):
- state=START, PAGE_SEL=0, IPORT=0, FEAT_IDX=0, LABEL=0.
- FEAT_REQ=0, LABEL_VALID=0, ERR=0, CORE_HOLD=0, CORE_RSTN=0.
- watchdog=0.
REQ-024 CORE_RSTN SHALL stay 0 for one cycle after RSTN deasserts, then go to 1.
REQ-025 RSTN assertion mid-FREQ or mid-PAGE SHALL abort immediately with the REQ-023 values; no FEAT_REQ pulse persists.

Verification
REQ-026 Direct path: SYM 1,0,1 from reset -> LABEL=3, LABEL_VALID=1 one cycle after the last symbol; SYM 2,0,2 -> LABEL=1.
REQ-027 Feature fetch: SYM 2,1,2, then OPORT=0x6 in FREQ, FEAT_ACK after 5 cycles with FEAT_DATA=0xA:
- FEAT_IDX=6, FEAT_REQ high 5 cycles, CORE_HOLD high during the wait.
- IPORT=0xA; SYM 3 returns to START.
REQ-028 Page change: SYM 1,2,1 on page 0:
- CORE_RSTN low 1 cycle, PAGE_SEL=2.
- INSTR=0x80 while PC is 5,3,1; PC=0 -> CHILD with INSTR=ROM_INSTR.
REQ-029 Invalid child: NPAGES=3, PAGE_SEL=2, SYM 1,2,0 -> child 5 -> ERR=1, LABEL_VALID=1, PAGE_SEL stays 2.
REQ-030 Watchdog: TIMEOUT_CYC=16, SYM held at 0 in START -> ERR=1 after 16 cycles; RSTN pulse clears all outputs per REQ-023.
